// File: rtl/lzc_normalizer_pipe_if.sv
// Handshake and data bundle for the leading-count normaliser: upstream beat
// in, normalised beat out. The master side drives the input beat and out_ready.
interface lzc_normalizer_pipe_if #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic             in_lead_one;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [CW-1:0]    out_cnt;
  logic             out_zero;
  logic             out_uflow;

  modport master (
    output in_valid, in_mant, in_exp, in_lead_one, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_cnt, out_zero, out_uflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_lead_one, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_cnt, out_zero, out_uflow
  );
endinterface

// File: rtl/lzc_normalizer_pipe.sv
// Two-stage leading-zero/leading-one counter and normaliser: stage 1 registers
// the count with its operands, stage 2 registers the shifted mantissa and flags.
module lzc_normalizer_pipe #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lzc_normalizer_pipe_if.slave bus
);
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int CMP_W = (CW > EXP_W) ? CW : EXP_W;

  // Handshake
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv       = !out_valid_reg || bus.out_ready;
  assign s1_adv       = s2_adv || !s1_valid_reg;
  assign accept       = bus.in_valid && s1_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1: MSB-first priority search for the first bit that differs from the mode bit
  logic [CW-1:0] lz_next;
  logic          found;

  always_comb begin
    lz_next = CW'(WIDTH);
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && (bus.in_mant[i] != bus.in_lead_one)) begin
        found   = 1'b1;
        lz_next = CW'(WIDTH - 1 - i);
      end
    end
  end

  logic [WIDTH-1:0] s1_mant_reg;
  logic [EXP_W-1:0] s1_exp_reg;
  logic [CW-1:0]    s1_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_mant_reg  <= '0;
      s1_exp_reg   <= '0;
      s1_cnt_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (accept) begin
        s1_mant_reg <= bus.in_mant;
        s1_exp_reg  <= bus.in_exp;
        s1_cnt_reg  <= lz_next;
      end
    end
  end

  // Stage 2: shift is clamped to the exponent so the subtraction never wraps
  logic [CMP_W-1:0] cnt_ext;
  logic [CMP_W-1:0] exp_ext;
  logic [CMP_W-1:0] shift;
  logic [WIDTH-1:0] mant_next;
  logic [EXP_W-1:0] exp_next;
  logic             zero_next;
  logic             uflow_next;

  assign cnt_ext = CMP_W'(s1_cnt_reg);
  assign exp_ext = CMP_W'(s1_exp_reg);

  always_comb begin
    shift      = '0;
    mant_next  = '0;
    exp_next   = '0;
    zero_next  = 1'b0;
    uflow_next = 1'b0;
    if (s1_cnt_reg == CW'(WIDTH)) begin
      zero_next = 1'b1;
    end else if (cnt_ext > exp_ext) begin
      shift      = exp_ext;
      uflow_next = 1'b1;
      mant_next  = s1_mant_reg << shift;
    end else begin
      shift     = cnt_ext;
      exp_next  = EXP_W'(exp_ext - cnt_ext);
      mant_next = s1_mant_reg << shift;
    end
  end

  logic [WIDTH-1:0] out_mant_reg;
  logic [EXP_W-1:0] out_exp_reg;
  logic [CW-1:0]    out_cnt_reg;
  logic             out_zero_reg;
  logic             out_uflow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_mant_reg  <= '0;
      out_exp_reg   <= '0;
      out_cnt_reg   <= '0;
      out_zero_reg  <= 1'b0;
      out_uflow_reg <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_mant_reg  <= mant_next;
        out_exp_reg   <= exp_next;
        out_cnt_reg   <= s1_cnt_reg;
        out_zero_reg  <= zero_next;
        out_uflow_reg <= uflow_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_mant  = out_mant_reg;
  assign bus.out_exp   = out_exp_reg;
  assign bus.out_cnt   = out_cnt_reg;
  assign bus.out_zero  = out_zero_reg;
  assign bus.out_uflow = out_uflow_reg;
endmodule

// File: tb/tb_lzc_normalizer_pipe.sv
// Scoreboard bench for lzc_normalizer_pipe at WIDTH=24, EXP_W=8: expected
// beats are queued on accept and compared in order on emit.
module tb_lzc_normalizer_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lzc_normalizer_pipe_if #(.WIDTH(24), .EXP_W(8)) bus ();

  lzc_normalizer_pipe #(.WIDTH(24), .EXP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [38:0] beat_t;  // {mant, exp, cnt, zero, uflow}
  beat_t sb[$];

  typedef struct packed {
    logic        lo;
    logic [23:0] m;
    logic [7:0]  e;
    beat_t       x;
  } vec_t;

  vec_t vecs [7] = '{
    '{1'b0, 24'h000001, 8'd100, {24'h800000, 8'd77, 5'd23, 1'b0, 1'b0}},
    '{1'b0, 24'h000000, 8'd50,  {24'h000000, 8'd0,  5'd24, 1'b1, 1'b0}},
    '{1'b0, 24'h001000, 8'd5,   {24'h020000, 8'd0,  5'd11, 1'b0, 1'b1}},
    '{1'b1, 24'hFFF0FF, 8'd20,  {24'h0FF000, 8'd8,  5'd12, 1'b0, 1'b0}},
    '{1'b1, 24'hFFFFFF, 8'd9,   {24'h000000, 8'd0,  5'd24, 1'b1, 1'b0}},
    '{1'b0, 24'h800000, 8'd0,   {24'h800000, 8'd0,  5'd0,  1'b0, 1'b0}},
    '{1'b0, 24'h000001, 8'd23,  {24'h800000, 8'd0,  5'd23, 1'b0, 1'b0}}
  };

  function automatic beat_t model(logic [23:0] m, logic [7:0] e, logic lo);
    int n = 0;
    while (n < 24 && m[23-n] == lo) n++;
    if (n == 24)
      return {24'h0, 8'h0, 5'd24, 1'b1, 1'b0};
    else if (n > int'(e))
      return {m << e, 8'h0, 5'(n), 1'b0, 1'b1};
    else
      return {m << n, e - 8'(n), 5'(n), 1'b0, 1'b0};
  endfunction

  function automatic beat_t out_beat();
    return {bus.out_mant, bus.out_exp, bus.out_cnt, bus.out_zero, bus.out_uflow};
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_exp = '0;
    bus.in_lead_one = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (out_beat() !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", out_beat());
    end
  endtask

  task automatic test_vectors();
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_mant = vecs[v].m; bus.in_exp = vecs[v].e;
      bus.in_lead_one = vecs[v].lo; bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_in_ready got %b want 1", v, bus.in_ready);
      end
      sb.push_back(vecs[v].x);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_latency_early got out_valid=%b want 0", v, bus.out_valid);
      end
      @(posedge clk); #2;
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_latency got out_valid=%b want 1", v, bus.out_valid);
      end else begin
        beat_t x = sb.pop_front();
        $display("vec%0d out %h expected %h", v, out_beat(), x);
        checks++;
        if (out_beat() !== x) begin
          errors++;
          $display("FAIL vec%0d_data got %h want %h", v, out_beat(), x);
        end
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] bm [8];
    logic [7:0]  be [8];
    logic        bl [8];
    int    sent = 0;
    int    got = 0;
    int    cyc = 0;
    logic  held = 1'b0;
    beat_t hold_val = '0;
    for (int i = 0; i < 8; i++) begin
      bl[i] = 1'($urandom_range(0, 1));
      bm[i] = 24'($urandom >> $urandom_range(8, 31));
      if (bl[i]) bm[i] = ~bm[i];
      be[i] = 8'($urandom_range(0, 30));
    end
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_mant = bm[sent]; bus.in_exp = be[sent]; bus.in_lead_one = bl[sent];
      end
      #1;
      if (held) begin
        checks++;
        if (bus.out_valid !== 1'b1 || out_beat() !== hold_val) begin
          errors++;
          $display("FAIL b2b_stall_hold got v=%b %h want v=1 %h", bus.out_valid, out_beat(), hold_val);
        end
      end
      checks++;
      if (bus.in_ready !== ((sb.size() < 2) || bus.out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc%0d got %b want %b", cyc, bus.in_ready,
                 (sb.size() < 2) || bus.out_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_beat got %h want none", out_beat());
        end else begin
          beat_t x = sb.pop_front();
          $display("b2b beat %0d out %h expected %h", got, out_beat(), x);
          if (out_beat() !== x) begin
            errors++;
            $display("FAIL b2b_data%0d got %h want %h", got, out_beat(), x);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_mant, bus.in_exp, bus.in_lead_one));
        sent++;
      end
      held = bus.out_valid && !bus.out_ready;
      hold_val = out_beat();
      cyc++;
    end
    checks++;
    if (got != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d beats (%0d queued) want 8 (0)", got, sb.size());
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_lead_one = 1'b0;
    bus.in_mant = 24'h000100; bus.in_exp = 8'd50;
    sb.push_back(model(bus.in_mant, bus.in_exp, 1'b0));
    @(posedge clk); #1;
    bus.in_mant = 24'h000200;
    sb.push_back(model(bus.in_mant, bus.in_exp, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_full got out_valid=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_cleared got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    sb.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale cyc%0d got out_valid=%b data %h want 0", i, bus.out_valid, out_beat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
